// File: rtl/pe_datapath.sv
// pe_datapath: N_PE parallel 3x3 convolver lanes feeding a registered adder
// tree, a feedback adder for partial sums and a non-linearity output stage.
// All arithmetic is signed fixed point and every stage saturates to WID bits.
// Ports:
//   clk, rst            clock, async active-low reset
//   shifting_line       per-lane shift of the bus word into the line buffer
//   shifting_filter     per-lane shift of the bus word into the filter register
//   mac_enable          per-lane MAC enable (disabled lane registers 0)
//   line_buffer_reset   synchronous clear of all line buffers
//   row_length          image row length R (3..2^ADDR_FIFO-1)
//   adder_enable        adder tree register update enable
//   feedback_enable     add input_2_PE to the tree result
//   nl_enable, nl_type  non-linearity select (0 ReLU, 1 leaky ReLU, else identity)
//   input_bus1_PE       lane i word at [i*WID +: WID]
//   input_2_PE          feedback partial sum
//   output_1_PE         registered PE result
module pe_datapath #(
  parameter int unsigned N_PE      = 4,
  parameter int unsigned WID       = 16,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned ADDR_FIFO = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PE-1:0]            shifting_line,
  input  logic [N_PE-1:0]            shifting_filter,
  input  logic [N_PE-1:0]            mac_enable,
  input  logic                       line_buffer_reset,
  input  logic [ADDR_FIFO-1:0]       row_length,
  input  logic                       adder_enable,
  input  logic                       feedback_enable,
  input  logic                       nl_enable,
  input  logic [15:0]                nl_type,
  input  logic [WID*N_PE-1:0]        input_bus1_PE,
  input  logic signed [WID-1:0]      input_2_PE,
  output logic [WID-1:0]             output_1_PE
);

  localparam int unsigned DEPTH = 2 * ((1 << ADDR_FIFO) - 1) + 3;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned PW    = 2 * WID;
  localparam int unsigned AW    = 2 * WID + 4;

  localparam logic signed [WID-1:0] WMAX = {1'b0, {(WID-1){1'b1}}};
  localparam logic signed [WID-1:0] WMIN = {1'b1, {(WID-1){1'b0}}};

  // Clamp a wide signed value into the WID signed range.
  function automatic logic signed [WID-1:0] sat(input logic signed [AW-1:0] v);
    if (v > AW'(WMAX))      return WMAX;
    else if (v < AW'(WMIN)) return WMIN;
    else                    return WID'(v);
  endfunction

  logic [N_PE*WID-1:0]   lane_flat;
  logic signed [AW-1:0]  tree_sum;
  logic signed [AW-1:0]  fb_sum;
  logic signed [WID-1:0] tree_q;
  logic signed [WID-1:0] fb_q;
  logic signed [WID-1:0] nl_c;

  for (genvar i = 0; i < N_PE; i++) begin : g_lane
    logic signed [WID-1:0] word;
    logic signed [WID-1:0] lbuf [DEPTH];
    logic signed [WID-1:0] filt [9];
    logic signed [WID-1:0] mac_q;
    logic [IW-1:0]         row_off [3];
    logic [IW-1:0]         idx;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc;

    assign word = $signed(input_bus1_PE[i*WID +: WID]);

    // Delay line: lbuf[d] holds the pixel written d shifts ago.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int d = 0; d < DEPTH; d++) lbuf[d] <= '0;
      end else if (line_buffer_reset) begin
        for (int d = 0; d < DEPTH; d++) lbuf[d] <= '0;
      end else if (shifting_line[i]) begin
        lbuf[0] <= word;
        for (int d = 1; d < DEPTH; d++) lbuf[d] <= lbuf[d-1];
      end
    end

    // Filter shift register: newest word enters at f[8].
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j < 9; j++) filt[j] <= '0;
      end else if (shifting_filter[i]) begin
        for (int j = 0; j < 8; j++) filt[j] <= filt[j+1];
        filt[8] <= word;
      end
    end

    // Tap k (row r = k/3, col c = k%3) sits (2-r)*R + (2-c) shifts back.
    always_comb begin
      row_off[0] = IW'(row_length) << 1;
      row_off[1] = IW'(row_length);
      row_off[2] = '0;
      idx  = '0;
      prod = '0;
      acc  = '0;
      for (int k = 0; k < 9; k++) begin
        idx  = row_off[k/3] + IW'(2 - (k % 3));
        prod = PW'(filt[k]) * PW'(lbuf[idx]);
        acc  = acc + AW'(prod);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)               mac_q <= '0;
      else if (mac_enable[i]) mac_q <= sat(acc >>> FRAC);
      else                    mac_q <= '0;
    end

    assign lane_flat[i*WID +: WID] = mac_q;
  end

  // Sum of all lane registers.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < N_PE; i++)
      tree_sum = tree_sum + AW'($signed(lane_flat[i*WID +: WID]));
  end

  assign fb_sum = AW'(tree_q) + AW'(input_2_PE);

  // Non-linearity only alters negative inputs.
  always_comb begin
    nl_c = fb_q;
    if (nl_enable && fb_q[WID-1]) begin
      if (nl_type == 16'd0)      nl_c = '0;
      else if (nl_type == 16'd1) nl_c = fb_q >>> 3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tree_q      <= '0;
      fb_q        <= '0;
      output_1_PE <= '0;
    end else begin
      if (adder_enable) tree_q <= sat(tree_sum);
      fb_q        <= feedback_enable ? sat(fb_sum) : tree_q;
      output_1_PE <= nl_c;
    end
  end

endmodule

// File: tb/tb_pe_datapath.sv
module tb_pe_datapath;
  localparam int N_PE = 4;
  localparam int WID  = 16;

  logic                  clk = 0;
  logic                  rst;
  logic [N_PE-1:0]       shifting_line, shifting_filter, mac_enable;
  logic                  line_buffer_reset;
  logic [5:0]            row_length;
  logic                  adder_enable, feedback_enable, nl_enable;
  logic [15:0]           nl_type;
  logic [WID*N_PE-1:0]   input_bus1_PE;
  logic signed [WID-1:0] input_2_PE;
  logic [WID-1:0]        output_1_PE;

  pe_datapath #(.N_PE(N_PE), .WID(WID), .FRAC(8), .ADDR_FIFO(6)) dut (
    .clk(clk), .rst(rst),
    .shifting_line(shifting_line), .shifting_filter(shifting_filter),
    .mac_enable(mac_enable), .line_buffer_reset(line_buffer_reset),
    .row_length(row_length), .adder_enable(adder_enable),
    .feedback_enable(feedback_enable), .nl_enable(nl_enable),
    .nl_type(nl_type), .input_bus1_PE(input_bus1_PE),
    .input_2_PE(input_2_PE), .output_1_PE(output_1_PE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    expv;
    string name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int   px;
    logic fb;
    int   in2;
    logic nl_en;
    int   nl_t;
    int   expv;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard: compare the queue head on its due cycle, away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].cyc == cyc) begin
        check(sb[0].name, int'($signed(output_1_PE)), sb[0].expv);
        void'(sb.pop_front());
      end else if (cyc > sb[0].cyc) begin
        check({sb[0].name, "_missed"}, cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_px(input logic [N_PE-1:0] m, input int v);
    input_bus1_PE = {N_PE{WID'(v)}};
    shifting_line = m;
    tick();
    shifting_line = '0;
  endtask

  task automatic shift_flt(input logic [N_PE-1:0] m, input int v);
    input_bus1_PE = {N_PE{WID'(v)}};
    shifting_filter = m;
    tick();
    shifting_filter = '0;
  endtask

  // One MAC cycle, then the tree cycle; result is due 4 edges after the MAC.
  task automatic conv(input logic [N_PE-1:0] m, input logic add, input string name, input int expv);
    sb_t e;
    e.cyc = cyc + 4; e.expv = expv; e.name = name;
    sb.push_back(e);
    mac_enable = m;
    tick();
    mac_enable = '0;
    adder_enable = add;
    tick();
    adder_enable = 0;
    repeat (3) tick();
  endtask

  initial begin
    vt[0]  = '{30000,  1'b1,   5000, 1'b0, 0,  32767};
    vt[1]  = '{30000,  1'b0,   5000, 1'b0, 0,  30000};
    vt[2]  = '{-3000,  1'b1, -30000, 1'b0, 0, -32768};
    vt[3]  = '{-800,   1'b0,      0, 1'b1, 0,      0};
    vt[4]  = '{-800,   1'b0,      0, 1'b1, 1,   -100};
    vt[5]  = '{-800,   1'b0,      0, 1'b0, 1,   -800};
    vt[6]  = '{800,    1'b0,      0, 1'b1, 0,    800};
    vt[7]  = '{800,    1'b0,      0, 1'b1, 1,    800};
    vt[8]  = '{-801,   1'b0,      0, 1'b1, 1,   -101};
    vt[9]  = '{-5,     1'b0,      0, 1'b1, 1,     -1};
    vt[10] = '{-800,   1'b0,      0, 1'b1, 7,   -800};

    rst = 0;
    shifting_line = '0; shifting_filter = '0; mac_enable = '0;
    line_buffer_reset = 0; row_length = 6'd4;
    adder_enable = 0; feedback_enable = 0; nl_enable = 1; nl_type = 16'd2;
    input_bus1_PE = '0; input_2_PE = '0;
    repeat (2) tick();
    check("reset_out", int'($signed(output_1_PE)), 0);
    rst = 1;
    tick();

    // Identity convolution over all lanes.
    repeat (9)  shift_flt('1, 256);
    repeat (11) shift_px('1, 256);
    conv('1, 1'b1, "identity", 9216);

    // Buffer clear wins over a simultaneous shift; filters survive.
    input_bus1_PE = {N_PE{16'd256}};
    line_buffer_reset = 1; shifting_line = '1;
    tick();
    line_buffer_reset = 0; shifting_line = '0;
    conv('1, 1'b1, "buf_clear", 0);
    repeat (11) shift_px('1, 256);
    conv('1, 1'b1, "buf_reload", 9216);

    // Async reset mid-stream clears the output at once.
    input_bus1_PE = {N_PE{16'h1234}};
    @(posedge clk); #2;
    rst = 0;
    #1;
    check("midreset_out", int'($signed(output_1_PE)), 0);
    tick();
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("post_reset_%0d", c), int'($signed(output_1_PE)), 0);
    end
    repeat (11) shift_px('1, 256);
    conv('1, 1'b1, "unloaded_filter", 0);

    // Window alignment on lane 0, R = 3.
    row_length = 6'd3;
    shift_flt(4'b0001, 256);
    repeat (8) shift_flt(4'b0001, 0);
    for (int p = 1; p <= 9; p++) shift_px(4'b0001, p * 256);
    conv(4'b0001, 1'b1, "window_oldest", 256);
    repeat (8) shift_flt(4'b0001, 0);
    shift_flt(4'b0001, 256);
    conv(4'b0001, 1'b1, "window_newest", 2304);

    // Shift in the MAC cycle is not seen until the next MAC.
    shift_px(4'b0001, 100);
    begin
      sb_t e;
      e.cyc = cyc + 4; e.expv = 100; e.name = "mac_same_cycle_shift";
      sb.push_back(e);
      input_bus1_PE = {N_PE{16'd200}};
      shifting_line = 4'b0001; mac_enable = 4'b0001;
      tick();
      shifting_line = '0; mac_enable = '0; adder_enable = 1;
      tick();
      adder_enable = 0;
      repeat (3) tick();
    end
    conv(4'b0001, 1'b1, "mac_next", 200);
    shift_px(4'b0001, 300);
    conv(4'b0001, 1'b0, "tree_hold", 200);

    // Feedback, saturation and non-linearity vectors (lane 0 passes pixel).
    for (int v = 0; v < 11; v++) begin
      feedback_enable = vt[v].fb;
      input_2_PE = WID'(vt[v].in2);
      nl_enable = vt[v].nl_en;
      nl_type = 16'(vt[v].nl_t);
      shift_px(4'b0001, vt[v].px);
      conv(4'b0001, 1'b1, $sformatf("vec_%0d", v), vt[v].expv);
    end

    for (int w = 0; w < 20 && sb.size() > 0; w++) tick();
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
